// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC generation and fetch queue feeding decode
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   fetch_en                   start/continue fetching when high
//   inst_add / inst_data       byte address to instruction memory, word returned combinationally
//   dec_valid/dec_ready        handshake toward decode for the queue head
//   dec_inst / dec_pc          head instruction (compressed zero-extended) and its PC
//   redirect_valid/redirect_pc branch/jump/trap target
//   fetch_err / fetch_err_pc   sticky misaligned-target flag and the offending target
module inst_fetch_unit #(
    parameter int INST_WIDTH                = 32,
    parameter int INST_MEMORY_ADDRESS_WIDTH = 16,
    parameter logic [INST_MEMORY_ADDRESS_WIDTH-1:0] RESET_PC = '0,
    parameter int FQ_DEPTH                  = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 fetch_en,
    output logic [INST_MEMORY_ADDRESS_WIDTH-1:0] inst_add,
    input  logic [INST_WIDTH-1:0]                inst_data,
    output logic                                 dec_valid,
    input  logic                                 dec_ready,
    output logic [INST_WIDTH-1:0]                dec_inst,
    output logic [INST_MEMORY_ADDRESS_WIDTH-1:0] dec_pc,
    input  logic                                 redirect_valid,
    input  logic [INST_MEMORY_ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                                 fetch_err,
    output logic [INST_MEMORY_ADDRESS_WIDTH-1:0] fetch_err_pc
);

    localparam int AW    = INST_MEMORY_ADDRESS_WIDTH;
    localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   pc, pc_nxt;

    logic [INST_WIDTH-1:0] q_inst [FQ_DEPTH];
    logic [AW-1:0]         q_pc   [FQ_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      count;

    logic                  is_full;
    logic                  redir;
    logic                  redir_bad;
    logic                  push;
    logic                  pop;
    logic                  is_rvc;
    logic [INST_WIDTH-1:0] push_inst;
    logic [AW-1:0]         pc_step;

    assign inst_add  = pc;
    assign is_full   = (count == CNT_W'(FQ_DEPTH));
    // Redirects are ignored once halted; the error state is only left by reset.
    assign redir     = redirect_valid && (state != HALT);
    assign redir_bad = redir && redirect_pc[0];
    // Fullness is judged before any same-cycle pop, so a drained slot is refilled a cycle later.
    assign push      = (state == FETCH) && !is_full && !redirect_valid;
    assign pop       = dec_valid && dec_ready && !redirect_valid;

    assign is_rvc    = (inst_data[1:0] != 2'b11);
    assign push_inst = is_rvc ? {{(INST_WIDTH-16){1'b0}}, inst_data[15:0]} : inst_data;
    assign pc_step   = is_rvc ? AW'(2) : AW'(4);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            IDLE:    if (fetch_en)  state_nxt = FETCH;
            FETCH:   if (!fetch_en) state_nxt = IDLE;
            default: state_nxt = HALT;
        endcase
        if (redir) begin
            // A taken redirect freezes the IDLE/FETCH state for that cycle.
            state_nxt = state;
            if (redir_bad) state_nxt = HALT;
            else           pc_nxt    = redirect_pc;
        end else if (push) begin
            pc_nxt = pc + pc_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            fetch_err    <= 1'b0;
            fetch_err_pc <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (redir_bad) begin
                fetch_err    <= 1'b1;
                fetch_err_pc <= redirect_pc;
            end
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (pop && !push) count <= count - CNT_W'(1);
            end
        end
    end

    // Entry storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= push_inst;
            q_pc[wr_ptr]   <= pc;
        end
    end

    assign dec_valid = (count != '0);
    assign dec_inst  = dec_valid ? q_inst[rd_ptr] : '0;
    assign dec_pc    = dec_valid ? q_pc[rd_ptr]   : '0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [15:0] inst_add;
    logic [31:0] inst_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [15:0] dec_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        fetch_err;
    logic [15:0] fetch_err_pc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [65536];

    typedef struct {
        logic [15:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_pc;
    int          m_state;   // 0 idle, 1 fetching, 2 halted
    logic        m_err;
    logic [15:0] m_err_pc;

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .INST_WIDTH(32), .INST_MEMORY_ADDRESS_WIDTH(16), .RESET_PC(16'h0000), .FQ_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .inst_add(inst_add),
        .inst_data(inst_data), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_inst(dec_inst), .dec_pc(dec_pc), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .fetch_err(fetch_err), .fetch_err_pc(fetch_err_pc)
    );

    function automatic logic [31:0] rd32(input logic [15:0] a);
        logic [15:0] a1, a2, a3;
        a1 = a + 16'd1;
        a2 = a + 16'd2;
        a3 = a + 16'd3;
        return {mem[a3], mem[a2], mem[a1], mem[a]};
    endfunction

    assign inst_data = rd32(inst_add);

    task automatic set_word(input logic [15:0] a, input logic [31:0] d);
        logic [15:0] b;
        for (int i = 0; i < 4; i++) begin
            b = a + 16'(i);
            mem[b] = d[8*i +: 8];
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = 16'h0000;
        m_state  = 0;
        m_err    = 1'b0;
        m_err_pc = 16'h0000;
        mq.delete();
    endtask

    // One clock: compare DUT to model at the falling edge, then advance the model.
    task automatic step();
        logic        can_push;
        logic [31:0] w;
        ent_t        e;
        @(negedge clk);
        chk("inst_add", 32'(inst_add), 32'(m_pc));
        chk("dec_valid", 32'(dec_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("dec_pc", 32'(dec_pc), 32'(mq[0].pc));
            chk("dec_inst", dec_inst, mq[0].inst);
        end
        chk("fetch_err", 32'(fetch_err), 32'(m_err));
        chk("fetch_err_pc", 32'(fetch_err_pc), 32'(m_err_pc));

        if (redirect_valid && m_state != 2) begin
            mq.delete();
            if (redirect_pc[0]) begin
                m_state  = 2;
                m_err    = 1'b1;
                m_err_pc = redirect_pc;
            end else begin
                m_pc = redirect_pc;
            end
        end else if (!redirect_valid || m_state == 2) begin
            can_push = (m_state == 1) && (mq.size() < 2) && !redirect_valid;
            if (dec_ready && mq.size() != 0 && !redirect_valid) void'(mq.pop_front());
            if (can_push) begin
                w = rd32(m_pc);
                e.pc = m_pc;
                if (w[1:0] == 2'b11) begin
                    e.inst = w;
                    m_pc   = m_pc + 16'd4;
                end else begin
                    e.inst = {16'h0000, w[15:0]};
                    m_pc   = m_pc + 16'd2;
                end
                mq.push_back(e);
            end
            if (m_state == 0 && fetch_en)       m_state = 1;
            else if (m_state == 1 && !fetch_en) m_state = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [15:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; fetch_en = 1'b0; dec_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 255));
        set_word(16'h0000, 32'h00500093);
        set_word(16'h0004, 32'h00A00113);
        set_word(16'h0010, 32'h05134501);   // compressed 4501, then 32-bit 00000513 at 0x12
        set_word(16'h0014, 32'h00000000);
        set_word(16'hFFFC, 32'h00000013);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_inst_add", 32'(inst_add), 32'h0);
        chk("rst_dec_inst", dec_inst, 32'h0);
        chk("rst_dec_pc", 32'(dec_pc), 32'h0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        rst_n = 1'b1;
        model_reset();

        // Boot
        fetch_en = 1'b1; dec_ready = 1'b1;
        step();
        step();
        chk("boot_add1", 32'(inst_add), 32'h4);
        chk("boot_pc0", 32'(dec_pc), 32'h0);
        chk("boot_inst0", dec_inst, 32'h00500093);
        step();
        chk("boot_pc1", 32'(dec_pc), 32'h4);
        chk("boot_inst1", dec_inst, 32'h00A00113);

        // Compressed followed by 32-bit
        redirect_to(16'h0010);
        chk("rvc_redir_add", 32'(inst_add), 32'h10);
        step();
        chk("rvc_add", 32'(inst_add), 32'h12);
        chk("rvc_inst", dec_inst, 32'h00004501);
        step();
        chk("rv32_add", 32'(inst_add), 32'h16);
        chk("rv32_pc", 32'(dec_pc), 32'h12);
        chk("rv32_inst", dec_inst, 32'h00000513);

        // Backpressure
        dec_ready = 1'b0;
        redirect_to(16'h0000);
        repeat (5) step();
        chk("bp_add", 32'(inst_add), 32'h8);
        chk("bp_pc", 32'(dec_pc), 32'h0);
        dec_ready = 1'b1;
        step();
        chk("bp_rel1", 32'(dec_pc), 32'h4);
        step();
        chk("bp_rel2", 32'(dec_pc), 32'h8);
        step();

        // Redirect with a full queue and a live handshake
        dec_ready = 1'b0;
        repeat (3) step();
        dec_ready = 1'b1;
        redirect_to(16'h0040);
        chk("rd_valid", 32'(dec_valid), 32'd0);
        chk("rd_add", 32'(inst_add), 32'h40);
        step();
        chk("rd_pc", 32'(dec_pc), 32'h40);
        chk("rd_valid2", 32'(dec_valid), 32'd1);
        step();

        // Fetch disable: queue still drains
        fetch_en = 1'b0; dec_ready = 1'b0;
        repeat (3) step();
        dec_ready = 1'b1;
        repeat (4) step();
        fetch_en = 1'b1;
        repeat (2) step();

        // PC wrap
        redirect_to(16'hFFFC);
        step();
        chk("wrap_add", 32'(inst_add), 32'h0);
        chk("wrap_pc", 32'(dec_pc), 32'hFFFC);
        step();

        // Asynchronous reset mid-cycle
        chk("ar_pre_valid", 32'(dec_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(dec_valid), 32'd0);
        chk("ar_add", 32'(inst_add), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (3) step();

        // Misaligned redirect
        redirect_to(16'h0041);
        chk("mis_err", 32'(fetch_err), 32'd1);
        chk("mis_err_pc", 32'(fetch_err_pc), 32'h41);
        chk("mis_valid", 32'(dec_valid), 32'd0);
        redirect_to(16'h0080);
        repeat (3) step();
        chk("mis_hold_pc", 32'(fetch_err_pc), 32'h41);
        chk("mis_hold_valid", 32'(dec_valid), 32'd0);
        chk("mis_ign_add", 32'(inst_add) == 32'h80 ? 32'd1 : 32'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mis_rst_err", 32'(fetch_err), 32'd0);
        chk("mis_rst_err_pc", 32'(fetch_err_pc), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Program-counter and fetch stage directly upstream of the instruction memory.
- Drives the memory byte address every cycle and captures the combinationally returned instruction word.
- Sizes each instruction as 32-bit or 16-bit compressed and advances the PC accordingly.
- Buffers fetched instructions with their PCs in a small queue toward decode under a valid/ready handshake; handles branch/jump redirects and misaligned-target errors.

Parameters:
INST_WIDTH, 32, instruction word width returned by memory
INST_MEMORY_ADDRESS_WIDTH, 16, byte address width driven to memory
RESET_PC, 0, PC loaded on reset
FQ_DEPTH, 2, fetch queue entries (power of two, >=2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
fetch_en  input  1  enables fetching when high
inst_add  output  INST_MEMORY_ADDRESS_WIDTH  byte address to instruction memory
inst_data  input  INST_WIDTH  instruction returned combinationally for inst_add
dec_valid  output  1  queue head valid toward decode
dec_ready  input  1  decode accepts head this cycle
dec_inst  output  INST_WIDTH  head instruction; upper 16 bits zeroed for compressed
dec_pc  output  INST_MEMORY_ADDRESS_WIDTH  PC of head instruction
redirect_valid  input  1  branch/jump/trap redirect
redirect_pc  input  INST_MEMORY_ADDRESS_WIDTH  redirect target byte address
fetch_err  output  1  sticky misaligned-target error
fetch_err_pc  output  INST_MEMORY_ADDRESS_WIDTH  offending target address

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low, and is the only reset in the block.
- Reset:
  - pc=RESET_PC; queue count=0; state=IDLE.
  - Outputs: dec_valid=0, dec_inst=0, dec_pc=0, fetch_err=0, fetch_err_pc=0.
  - inst_add=RESET_PC.
  - Reset asserted mid-operation discards all queue contents immediately.
- inst_add = pc, combinational from the pc register, in all states.
- States:
  - IDLE -> FETCH when fetch_en=1.
  - FETCH -> IDLE when fetch_en=0; queue contents retained and still drain to decode.
  - Any state -> HALT on a misaligned redirect.
  - HALT is left only by reset.
- Push: occurs in FETCH when count<FQ_DEPTH and redirect_valid=0.
  - Entry = {pc, instruction}.
  - inst_data[1:0]==2'b11: 32-bit instruction; entry takes the full word; pc += 4.
  - Otherwise: compressed; entry takes {16'h0, inst_data[15:0]}; pc += 2.
- Stall: count==FQ_DEPTH means no push and pc holds. A pop in the same cycle does not enable a push; the push resumes the next cycle.
- PC arithmetic is modulo 2^INST_MEMORY_ADDRESS_WIDTH; wraps from all-ones region to 0 silently.
- Pop: occurs when dec_valid && dec_ready.
  - dec_valid = (count!=0).
  - dec_inst/dec_pc reflect the head entry and are stable while dec_valid=1 and dec_ready=0.
- Simultaneous push and pop: count unchanged; FIFO order preserved.
- Redirect (redirect_valid=1) has priority over push and pop:
  - Queue flushed (count=0 next cycle).
  - Any dec handshake in the same cycle is killed.
  - No push that cycle.
  - redirect_pc[0]==0: pc=redirect_pc next cycle; state unchanged (IDLE stays IDLE).
  - redirect_pc[0]==1: pc unchanged; state=HALT; fetch_err=1; fetch_err_pc=redirect_pc.
- Latency: a redirect in cycle N drives inst_add=target in N+1. In FETCH, dec_valid=1 with that target in N+2.
- Throughput: one instruction per cycle while decode is ready.
- HALT:
  - No pushes, pc frozen.
  - Queue stays empty, dec_valid=0.
  - Further redirects ignored; fetch_err and fetch_err_pc hold.

Test Plan:
- Reset/boot:
  - Stimulus: rst_n low then high; fetch_en=1; dec_ready=1; mem[0]=32'h00500093, mem[4]=32'h00A00113.
  - Response: inst_add=0 then 4; dec_pc/dec_inst = 0/00500093 then 4/00A00113 on consecutive cycles.
- Compressed:
  - Stimulus: mem[0x10]=32'h????4501, pc=0x10.
  - Response: dec_inst=32'h00004501; next inst_add=0x12.
  - Follow-up: 32-bit instruction at 0x12 (low halfword ends in 2'b11) gives next inst_add=0x16.
- Backpressure:
  - Stimulus: dec_ready=0 for 5 cycles from pc=0.
  - Response: count saturates at 2; pc holds at 8; dec_pc stays 0.
  - Release: dec_ready=1 delivers pc 0, 4, 8 in order with no loss or duplication.
- Redirect:
  - Stimulus: queue full; redirect_valid=1, redirect_pc=0x40, same cycle as dec_ready=1.
  - Response: next cycle count=0 and inst_add=0x40; following cycle dec_pc=0x40; no stale PC appears.
- Misaligned:
  - Stimulus: redirect_pc=0x41.
  - Response: fetch_err=1, fetch_err_pc=0x41, dec_valid=0 permanently; a later redirect to 0x80 ignored; asserting rst_n low clears fetch_err.
- Wrap/async reset:
  - Stimulus: pc=0xFFFC with a 32-bit instruction.
  - Response: next inst_add=0x0000.
  - Then: rst_n pulsed low mid-cycle gives immediate dec_valid=0 and inst_add=RESET_PC without waiting for a clock edge.
